// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client round-robin arbiter in front of the shared ALU.
// A granted request drives the ALU in the same cycle. The ALU result is
// registered and returned to the winning client one cycle later.
// Optional feature: define ALU_ARB_LOCK_EN to add the FREE/LOCK0/LOCK1 lock
// machine, which lets a client keep the grant across several operations.
// Handshake: a request completes in a cycle where reqN && gntN. The client
// holds op/ty/a/b stable while reqN=1 and gntN=0. Responses have no
// backpressure; rsp_* are valid only in the cycle where rsp_valid=1.
module alu_arbiter #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [2:0]   op0,
   input  logic [2:0]   op1,
   input  logic [1:0]   ty0,
   input  logic [1:0]   ty1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   input  logic         lock0,
   input  logic         lock1,
   output logic         gnt0,
   output logic         gnt1,
   output logic [2:0]   alu_ALUOp,
   output logic [1:0]   alu_opType,
   output logic [W-1:0] alu_ina,
   output logic [W-1:0] alu_inb,
   input  logic [W-1:0] alu_out,
   input  logic         alu_zero,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         rsp_zero,
   output logic         rsp_nop,
   output logic [1:0]   lock_state   // debug view of the lock machine (FREE when not built)
);

   typedef enum logic [1:0] {FREE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} lock_t;

   logic         last;        // id of the most recent grant
   logic         hold0;       // client 0 owns the ALU through a lock this cycle
   logic         hold1;
   logic         any_gnt;
   logic         sel;         // winner id
   logic [2:0]   sel_op;
   logic [1:0]   sel_ty;
   logic [W-1:0] sel_a;
   logic [W-1:0] sel_b;
   logic         is_nop;
   logic         drive_alu;

`ifdef ALU_ARB_LOCK_EN
   lock_t state;
   lock_t state_nxt;

   // Lock state register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= FREE;
      else          state <= state_nxt;
   end

   // Lock next-state: enter on a locked grant, leave on an unlocked grant or
   // when the owner stops requesting. The abandon cycle acts as a free cycle,
   // so the other client may take the grant (and a lock) right away.
   always_comb begin
      state_nxt = state;
      case (state)
         FREE: begin
            if (gnt0 && lock0)      state_nxt = LOCK0;
            else if (gnt1 && lock1) state_nxt = LOCK1;
         end
         LOCK0: begin
            if (!req0)               state_nxt = (gnt1 && lock1) ? LOCK1 : FREE;
            else if (gnt0 && !lock0) state_nxt = FREE;
         end
         LOCK1: begin
            if (!req1)               state_nxt = (gnt0 && lock0) ? LOCK0 : FREE;
            else if (gnt1 && !lock1) state_nxt = FREE;
         end
         default: state_nxt = FREE;
      endcase
   end

   // Lock outputs: the owner keeps the ALU only while it is still requesting.
   always_comb begin
      hold0      = (state == LOCK0) && req0;
      hold1      = (state == LOCK1) && req1;
      lock_state = state;
   end
`else
   logic unused_lock;

   // Without the lock machine, arbitration is pure round-robin.
   always_comb begin
      hold0       = 1'b0;
      hold1       = 1'b0;
      lock_state  = FREE;
      unused_lock = lock0 | lock1;
   end
`endif

   // Grant: a locked owner first; on a conflict the client that did not win last time; otherwise the sole requester.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (hold0)              gnt0 = 1'b1;
      else if (hold1)         gnt1 = 1'b1;
      else if (req0 && req1) begin
         gnt0 = last;
         gnt1 = !last;
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
      if (!Reset_n) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   // Winner field mux and no-op decode (jump, and the 111/11 encoding).
   always_comb begin
      any_gnt   = gnt0 | gnt1;
      sel       = gnt1;
      sel_op    = sel ? op1 : op0;
      sel_ty    = sel ? ty1 : ty0;
      sel_a     = sel ? a1  : a0;
      sel_b     = sel ? b1  : b0;
      is_nop    = (sel_op == 3'b110) || ({sel_op, sel_ty} == 5'b11111);
      drive_alu = any_gnt && !is_nop;
   end

   // The ALU sees all-zero controls and operands except in a real (non-no-op) grant cycle.
   always_comb begin
      alu_ALUOp  = drive_alu ? sel_op : 3'b000;
      alu_opType = drive_alu ? sel_ty : 2'b00;
      alu_ina    = drive_alu ? sel_a  : '0;
      alu_inb    = drive_alu ? sel_b  : '0;
   end

   // Response register and round-robin pointer; the data fields hold between responses.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_zero  <= 1'b0;
         rsp_nop   <= 1'b0;
         last      <= 1'b1;
      end else begin
         rsp_valid <= any_gnt;
         if (any_gnt) begin
            rsp_id   <= sel;
            rsp_nop  <= is_nop;
            rsp_data <= is_nop ? '0 : alu_out;
            rsp_zero <= is_nop ? 1'b0 : alu_zero;
            last     <= sel;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small stand-in ALU.
// Build with +define+ALU_ARB_LOCK_EN to include the lock scenarios.
module tb_alu_arbiter;
   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Reset_n;
   logic         req0, req1, lock0, lock1;
   logic [2:0]   op0, op1;
   logic [1:0]   ty0, ty1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         gnt0, gnt1;
   logic [2:0]   alu_ALUOp;
   logic [1:0]   alu_opType;
   logic [W-1:0] alu_ina, alu_inb, alu_out;
   logic         alu_zero;
   logic         rsp_valid, rsp_id, rsp_zero, rsp_nop;
   logic [W-1:0] rsp_data;
   logic [1:0]   lock_state;

   int checks = 0;
   int errors = 0;
   // Expected responses: {id, nop, zero, data}
   logic [W+2:0] exp_q[$];

   alu_arbiter #(.W(W)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1), .ty0(ty0), .ty1(ty1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .lock0(lock0), .lock1(lock1),
      .gnt0(gnt0), .gnt1(gnt1), .alu_ALUOp(alu_ALUOp), .alu_opType(alu_opType),
      .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_nop(rsp_nop), .lock_state(lock_state)
   );

   // Clock.
   always #5 Clk = ~Clk;

   // Toy ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shift-left by opType, others add.
   function automatic logic [W-1:0] model_alu(input logic [2:0] op, input logic [1:0] ty,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << ty;
         default: return a + b;
      endcase
   endfunction

   // Stand-in ALU driven by the arbiter.
   always_comb begin
      alu_out  = model_alu(alu_ALUOp, alu_opType, alu_ina, alu_inb);
      alu_zero = (alu_out == '0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set0(input logic r, input logic [2:0] op, input logic [1:0] ty,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic lk);
      req0 = r; op0 = op; ty0 = ty; a0 = a; b0 = b; lock0 = lk;
   endtask

   task automatic set1(input logic r, input logic [2:0] op, input logic [1:0] ty,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic lk);
      req1 = r; op1 = op; ty1 = ty; a1 = a; b1 = b; lock1 = lk;
   endtask

   // One cycle: check grants and ALU drive, push the expected response, then check the response after the edge.
   task automatic step(input logic eg0, input logic eg1, input string tag);
      logic [2:0]   eop;
      logic [1:0]   ety;
      logic [W-1:0] ea, eb, res;
      logic         nop;
      #1;
      check({tag, "_gnt0"}, 32'(gnt0), 32'(eg0));
      check({tag, "_gnt1"}, 32'(gnt1), 32'(eg1));
      eop = eg1 ? op1 : op0;
      ety = eg1 ? ty1 : ty0;
      ea  = eg1 ? a1  : a0;
      eb  = eg1 ? b1  : b0;
      nop = (eop == 3'b110) || ({eop, ety} == 5'b11111);
      if (eg0 || eg1) begin
         res = model_alu(eop, ety, ea, eb);
         if (nop) exp_q.push_back({eg1, 1'b1, 1'b0, {W{1'b0}}});
         else     exp_q.push_back({eg1, 1'b0, (res == '0), res});
      end
      if (!(eg0 || eg1) || nop) begin
         check({tag, "_alu_op"}, 32'(alu_ALUOp), 32'd0);
         check({tag, "_alu_a"},  32'(alu_ina),   32'd0);
      end else begin
         check({tag, "_alu_op"}, 32'(alu_ALUOp), 32'(eop));
         check({tag, "_alu_a"},  32'(alu_ina),   32'(ea));
         check({tag, "_alu_b"},  32'(alu_inb),   32'(eb));
      end
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
         logic [W+2:0] e;
         e = exp_q.pop_front();
         check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_rsp_id"},    32'(rsp_id),    32'(e[W+2]));
         check({tag, "_rsp_nop"},   32'(rsp_nop),   32'(e[W+1]));
         check({tag, "_rsp_zero"},  32'(rsp_zero),  32'(e[W]));
         check({tag, "_rsp_data"},  32'(rsp_data),  32'(e[W-1:0]));
      end else begin
         check({tag, "_rsp_idle"},  32'(rsp_valid), 32'd0);
      end
   endtask

   task automatic idle_inputs();
      set0(1'b0, 3'd0, 2'd0, '0, '0, 1'b0);
      set1(1'b0, 3'd0, 2'd0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      idle_inputs();
      exp_q.delete();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   // Directed sequence.
   initial begin
      Reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge Clk);
      #1;
      // Grants and ALU forced low while reset is held, even with requests present.
      set0(1'b1, 3'd0, 2'd0, 8'h11, 8'h22, 1'b0);
      set1(1'b1, 3'd0, 2'd0, 8'h33, 8'h44, 1'b0);
      #1;
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_alu_a", 32'(alu_ina), 32'd0);
      check("rst_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_nop, rsp_data}, 32'd0);
      @(posedge Clk);
      #1;
      idle_inputs();
      Reset_n = 1'b1;

      // Single ADD from client 0.
      set0(1'b1, 3'd0, 2'd0, 8'h05, 8'h03, 1'b0);
      step(1'b1, 1'b0, "add0");
      idle_inputs();
      step(1'b0, 1'b0, "idle_a");

      // Continuous conflict from reset: 0,1,0,1,0,1.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set0(1'b1, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
         set1(1'b1, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
         step((i % 2) == 0, (i % 2) == 1, $sformatf("rr%0d", i));
      end
      idle_inputs();

      // Zero-result flag through the response path.
      set1(1'b1, 3'd1, 2'd0, 8'h5a, 8'h5a, 1'b0);
      step(1'b0, 1'b1, "sub_zero");

      // No-op encodings and a near miss that is a real op.
      set1(1'b1, 3'b110, 2'b00, 8'h12, 8'h34, 1'b0);
      step(1'b0, 1'b1, "nop_jump");
      set1(1'b1, 3'b111, 2'b11, 8'h56, 8'h78, 1'b0);
      step(1'b0, 1'b1, "nop_111_11");
      set1(1'b1, 3'b111, 2'b00, 8'h01, 8'h02, 1'b0);
      step(1'b0, 1'b1, "op_111_00");
      idle_inputs();
      step(1'b0, 1'b0, "idle_b");

      // Reset one cycle after a grant: response drops at once, and client 0 wins the next conflict.
      set0(1'b1, 3'd4, 2'd0, 8'hf0, 8'h0f, 1'b0);
      step(1'b1, 1'b0, "pre_mid_rst");
      Reset_n = 1'b0;
      #1;
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_gnt0", 32'(gnt0), 32'd0);
      exp_q.delete();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      idle_inputs();
      step(1'b0, 1'b0, "after_rst");
      set0(1'b1, 3'd2, 2'd0, 8'hcc, 8'haa, 1'b0);
      set1(1'b1, 3'd3, 2'd0, 8'h01, 8'h10, 1'b0);
      step(1'b1, 1'b0, "rst_last");
      idle_inputs();
      step(1'b0, 1'b0, "idle_c");

`ifdef ALU_ARB_LOCK_EN
      // Client 0 holds a lock for three ops while client 1 keeps requesting.
      do_reset();
      set1(1'b1, 3'd0, 2'd0, 8'h09, 8'h09, 1'b0);
      set0(1'b1, 3'd0, 2'd0, 8'h01, 8'h02, 1'b1);
      step(1'b1, 1'b0, "lk_a");
      check("lk_state_a", 32'(lock_state), 32'd1);
      set0(1'b1, 3'd3, 2'd0, 8'h30, 8'h03, 1'b1);
      step(1'b1, 1'b0, "lk_b");
      check("lk_state_b", 32'(lock_state), 32'd1);
      set0(1'b1, 3'd1, 2'd0, 8'h40, 8'h01, 1'b0);
      step(1'b1, 1'b0, "lk_c");
      check("lk_state_c", 32'(lock_state), 32'd0);
      step(1'b0, 1'b1, "lk_release");
      // Lock abandon: req0 drops while in LOCK0 and client 1 takes that cycle.
      set0(1'b1, 3'd0, 2'd0, 8'h07, 8'h08, 1'b1);
      step(1'b1, 1'b0, "lk_enter");
      check("lk_state_enter", 32'(lock_state), 32'd1);
      set0(1'b0, 3'd0, 2'd0, '0, '0, 1'b0);
      step(1'b0, 1'b1, "lk_abandon");
      check("lk_state_abandon", 32'(lock_state), 32'd0);
      idle_inputs();
      step(1'b0, 1'b0, "idle_d");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared ALU. Accepts operation requests (ALUOp, opType, two operands) from two clients, such as the core issue stage and a test/debug port. Grants one request per cycle with round-robin fairness and drives the ALU control decoder and operand inputs. Registers the ALU result and returns it to the winning client one cycle later.

## Interface
- `W`, 8: operand/result width.
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous active-low reset.
- `req0`, `req1`  in  1  request valid, client 0 / 1.
- `op0`, `op1`  in  3  ALUOp field of request.
- `ty0`, `ty1`  in  2  opType field of request.
- `a0`, `b0`, `a1`, `b1`  in  W  operands.
- `lock0`, `lock1`  in  1  hold grant after this op (only with `ALU_ARB_LOCK_EN`).
- `gnt0`, `gnt1`  out  1  request accepted this cycle (combinational).
- `alu_ALUOp`  out  3  to ALU control decoder.
- `alu_opType`  out  2  to ALU control decoder.
- `alu_ina`, `alu_inb`  out  W  ALU operands.
- `alu_out`  in  W  ALU result (combinational from ALU).
- `alu_zero`  in  1  ALU zero flag.
- `rsp_valid`  out  1  registered response valid.
- `rsp_id`  out  1  client that owns the response.
- `rsp_data`  out  W  registered result.
- `rsp_zero`  out  1  registered zero flag.
- `rsp_nop`  out  1  request was a no-op; data forced to 0.

## Operation
- A handshake completes when `reqN && gntN`. The client holds all fields stable while `reqN` is high and `gntN` is low. At most one `gnt` is high per cycle.
- Arbitration is round-robin on a registered pointer `last` (id of the last grant). On a conflict, the client `!last` wins. A sole requester always wins. The pointer updates only on a grant.
- The ALU is driven only in a grant cycle, with the winner's fields. In all other cycles, ALU outputs are 0 (`alu_ALUOp=3'b000`, `alu_opType=2'b00`, operands 0).
- No-op encodings are `ALUOp=3'b110` (jump) and `{ALUOp,opType}={3'b111,2'b11}`.
  - They are granted normally, but the ALU outputs stay at 0.
  - The response carries `rsp_nop=1`, `rsp_data=0`, `rsp_zero=0`.
- Response register:
  - On a grant cycle, it captures `alu_out`/`alu_zero` (or the no-op values), the winner id, and sets `rsp_valid=1` at the next edge.
  - Otherwise `rsp_valid=0` at the next edge; the data fields hold their value.
- Responses have no backpressure; clients must consume `rsp_*` in the cycle `rsp_valid` is high.
- Lock state machine (with `ALU_ARB_LOCK_EN`), states FREE, LOCK0, LOCK1:
  - FREE → LOCKN when client N is granted with `lockN=1`.
  - In LOCKN, only client N can be granted. The other client's `gnt` stays 0 regardless of `last`.
  - LOCKN → FREE on a client-N grant with `lockN=0`, or when `reqN=0` for any cycle (lock abandon).
  - LOCKN persists while `reqN=1` and not granted. This cannot occur, since N always wins in LOCKN.
- Reset (async, `Reset_n=0`):
  - `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_zero=0`, `rsp_nop=0`.
  - `last=1`, so client 0 wins the first conflict.
  - Lock state is FREE.
  - `gnt*` and `alu_*` are forced to 0 while reset is asserted.
  - Reset mid-operation drops any pending response; no response is issued for a grant in the cycle reset asserts.

## Timing
- Grant is combinational from `req*`, lock state and `last`, in the same cycle.
- ALU is driven in cycle N, and the result is captured at the end of N. `rsp_valid` is high in cycle N+1. Latency is 1 cycle.
- Throughput is 1 op/cycle. Back-to-back grants produce back-to-back responses.
- Under continuous requests from both clients with no lock, grants alternate 0,1,0,1…; each client waits at most 1 cycle.

## Configuration
- `ALU_ARB_LOCK_EN` defined: `lock0`/`lock1` are honoured and the FREE/LOCK0/LOCK1 machine is built.
- `ALU_ARB_LOCK_EN` undefined: lock inputs are ignored, the lock FSM is absent, and arbitration is pure round-robin.

## Test plan
- Reset release, then `req0` only with ADD, a0=8'h05, b0=8'h03 → `gnt0=1` the same cycle; next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_data=8'h08`, `rsp_nop=0`.
- Both clients request continuously for 6 cycles from reset → grant order 0,1,0,1,0,1; responses follow each grant by 1 cycle with matching `rsp_id`.
- Client 1 requests `{3'b110,2'b00}` → `gnt1=1`, `alu_ALUOp=0`; next cycle `rsp_nop=1`, `rsp_data=0`. Repeat with `{3'b111,2'b11}` → same result.
- With lock: client 0 is granted with `lock0=1` for 3 ops while `req1` stays high → grants 0,0,0. Then `lock0=0` on the third op, and the next grant goes to client 1.
- With lock: in LOCK0, `req0` drops for one cycle → state returns to FREE and client 1 is granted that cycle.
- Assert `Reset_n=0` in the cycle after a grant → `rsp_valid` drops to 0 immediately (async); after release no stale response appears and `last=1`.
